// File: rtl/fixed_point_divider_if.sv
// Operand/result handshake bundle for fixed_point_divider.
// The master drives operands and accepts results; the slave is the divider.
interface fixed_point_divider_if #(
    parameter int W = 33
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] y_out;
    logic         overflow_o;
    logic         div_by_zero_o;

    modport master (
        output in_valid_i, a_in, b_in, out_ready_i,
        input  in_ready_o, out_valid_o, y_out, overflow_o, div_by_zero_o
    );

    modport slave (
        input  in_valid_i, a_in, b_in, out_ready_i,
        output in_ready_o, out_valid_o, y_out, overflow_o, div_by_zero_o
    );
endinterface

// File: rtl/fixed_point_divider.sv
// Sequential sign-magnitude Qm.n divider, y = a / b.
// Restoring division producing one quotient bit per clock. The dividend and
// quotient share one shift register: each cycle the MSB leaves as the next
// dividend bit and the new quotient bit enters at the LSB.
// Optional build macro FIXED_POINT_DIVIDER_ROUND_EN: compute one guard
// quotient bit and round half up on the magnitude (latency grows by one).
module fixed_point_divider #(
    parameter int q_m = 17,
    parameter int q_n = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    fixed_point_divider_if.slave   bus
);
    localparam int W = q_m + q_n;
    localparam int M = W - 1;
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int ITER = M + q_n + 1;
`else
    localparam int ITER = M + q_n;
`endif
    // Zero bits appended below |a| to form the scaled dividend
    localparam int SH = ITER - M;
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    rem_q, rem_d;
    logic [ITER-1:0] dq_q, dq_d;
    logic [M-1:0]    mag_b_q, mag_b_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    y_q, y_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;

    logic [M:0]      shifted;
    logic [M:0]      trial;
    logic            qbit;
    logic [M:0]      ovf_mag;
    logic            res_sign;

    // Quotient magnitude with saturation; returns {overflow, magnitude}
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    function automatic logic [M:0] quot_mag(input logic [ITER-1:0] q);
        logic [ITER-2:0] qh;
        logic [M:0]      sum;
        qh  = q[ITER-1:1];
        sum = {1'b0, qh[M-1:0]} + {{M{1'b0}}, q[0]};
        if ((|qh[ITER-2:M]) || sum[M])
            return {1'b1, {M{1'b1}}};
        return {1'b0, sum[M-1:0]};
    endfunction
`else
    function automatic logic [M:0] quot_mag(input logic [ITER-1:0] q);
        if (|q[ITER-1:M])
            return {1'b1, {M{1'b1}}};
        return {1'b0, q[M-1:0]};
    endfunction
`endif

    // One restoring-division step and the next-state/output logic
    always_comb begin
        shifted     = {rem_q, dq_q[ITER-1]};
        qbit        = (shifted >= {1'b0, mag_b_q});
        trial       = shifted - {1'b0, mag_b_q};
        ovf_mag     = quot_mag(dq_q);
        res_sign    = 1'b0;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dq_d        = dq_q;
        mag_b_d     = mag_b_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (bus.in_valid_i && in_ready_q) begin
                    sign_a_d   = bus.a_in[W-1];
                    sign_b_d   = bus.b_in[W-1];
                    mag_b_d    = bus.b_in[M-1:0];
                    dq_d       = {bus.a_in[M-1:0], {SH{1'b0}}};
                    rem_d      = '0;
                    cnt_d      = CW'(ITER);
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                in_ready_d = 1'b0;
                if (cnt_q != '0) begin
                    // Keep the subtraction when it fits, otherwise restore
                    rem_d = qbit ? trial[M-1:0] : shifted[M-1:0];
                    dq_d  = {dq_q[ITER-2:0], qbit};
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (mag_b_q == '0) begin
                        // Divide by zero: saturate with the dividend's sign
                        y_d   = {sign_a_q, {M{1'b1}}};
                        ovf_d = 1'b0;
                        dbz_d = 1'b1;
                    end else begin
                        // No negative zero
                        res_sign = (sign_a_q ^ sign_b_q) & (|ovf_mag[M-1:0]);
                        y_d      = {res_sign, ovf_mag[M-1:0]};
                        ovf_d    = ovf_mag[M];
                        dbz_d    = 1'b0;
                    end
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                in_ready_d = 1'b0;
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dq_q        <= '0;
            mag_b_q     <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dq_q        <= dq_d;
            mag_b_q     <= mag_b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.in_ready_o    = in_ready_q;
    assign bus.out_valid_o   = out_valid_q;
    assign bus.y_out         = y_q;
    assign bus.overflow_o    = ovf_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider at default Q17.16 format.
module tb_fixed_point_divider;
`ifdef FIXED_POINT_DIVIDER_ROUND_EN
    localparam int LAT = 50;
    localparam logic [32:0] Y_TWO_THIRDS = 33'h0_0000_AAAB;
`else
    localparam int LAT = 49;
    localparam logic [32:0] Y_TWO_THIRDS = 33'h0_0000_AAAA;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    fixed_point_divider_if #(.W(33)) bus ();

    fixed_point_divider dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Issue one operation, measure latency, check result, optionally stall
    task automatic run_op(input string tag, input logic [32:0] a, input logic [32:0] b,
                          input logic [32:0] exp_y, input logic exp_ovf,
                          input logic exp_dbz, input int hold);
        int   edges;
        logic ready_bad;
        logic unstable;
        logic [32:0] y_seen;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(bus.in_ready_o), 64'd1);
        bus.a_in       = a;
        bus.b_in       = b;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        ready_bad = bus.in_ready_o;
        edges = 0;
        while (!bus.out_valid_o && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (bus.in_ready_o) ready_bad = 1'b1;
        end
        chk({tag, "_latency"}, 64'(edges), 64'(LAT));
        chk({tag, "_y"}, 64'(bus.y_out), 64'(exp_y));
        chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'(exp_ovf));
        chk({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'(exp_dbz));
        if (hold > 0) begin
            y_seen   = bus.y_out;
            unstable = 1'b0;
            bus.a_in       = 33'h0_0001_0000;
            bus.b_in       = 33'h0_0001_0000;
            bus.in_valid_i = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                if (bus.y_out !== y_seen || !bus.out_valid_o) unstable = 1'b1;
                if (bus.in_ready_o) ready_bad = 1'b1;
            end
            chk({tag, "_hold_stable"}, 64'(unstable), 64'd0);
            @(negedge clk);
            bus.in_valid_i = 1'b0;
        end
        chk({tag, "_in_ready_busy"}, 64'(ready_bad), 64'd0);
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        chk({tag, "_valid_drop"}, 64'(bus.out_valid_o), 64'd0);
        chk({tag, "_flags_clr"}, 64'({bus.overflow_o, bus.div_by_zero_o}), 64'd0);
        chk({tag, "_in_ready_back"}, 64'(bus.in_ready_o), 64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_y", 64'(bus.y_out), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_o), 64'd0);
        chk("rst_dbz", 64'(bus.div_by_zero_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("3_div_1p5", 33'h0_0003_0000, 33'h0_0001_8000, 33'h0_0002_0000, 1'b0, 1'b0, 0);
        run_op("neg3_div_1p5", 33'h1_0003_0000, 33'h0_0001_8000, 33'h1_0002_0000, 1'b0, 1'b0, 0);
        run_op("zero_div_neg1", 33'h0_0000_0000, 33'h1_0001_0000, 33'h0_0000_0000, 1'b0, 1'b0, 0);
        run_op("2_div_3", 33'h0_0002_0000, 33'h0_0003_0000, Y_TWO_THIRDS, 1'b0, 1'b0, 0);
        run_op("1_div_3", 33'h0_0001_0000, 33'h0_0003_0000, 33'h0_0000_5555, 1'b0, 1'b0, 0);
        run_op("overflow", 33'h0_8000_0000, 33'h0_0000_8000, 33'h0_FFFF_FFFF, 1'b1, 1'b0, 0);
        run_op("div_zero", 33'h1_0005_0000, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 1'b0, 1'b1, 0);
        run_op("hold_7_div_neg2", 33'h0_0007_0000, 33'h1_0002_0000, 33'h1_0003_8000, 1'b0, 1'b0, 10);

        // Reset in the middle of a calculation
        @(negedge clk);
        bus.a_in       = 33'h0_0009_0000;
        bus.b_in       = 33'h0_0002_0000;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready_o), 64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("midrst_y", 64'(bus.y_out), 64'd0);
        chk("midrst_flags", 64'({bus.overflow_o, bus.div_by_zero_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst_9_div_2", 33'h0_0009_0000, 33'h0_0002_0000, 33'h0_0004_8000, 1'b0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
- Sequential sign-magnitude fixed-point divider computing y = a / b.
- Uses the same Qm.n word format as the perceptron datapath's fixed-point multiplier: MSB is the sign, the low W-1 bits are the magnitude, and q_n of those bits are fractional.
- Provides the inverse operation for normalisation and learning-rate scaling in the perceptron.
- Iterative restoring division, one quotient bit per cycle, with valid/ready handshakes on both sides.

Parameters:
- q_m, 17, integer field width including the sign bit. Word width W = q_m + q_n; magnitude width M = W - 1.
- q_n, 16, fractional bit count.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  operands present.
- in_ready_o  output  1  divider idle, can accept operands.
- a_in  input  W  dividend, sign-magnitude.
- b_in  input  W  divisor, sign-magnitude.
- out_valid_o  output  1  result valid; held until it is consumed.
- out_ready_i  input  1  consumer accepts the result.
- y_out  output  W  quotient, sign-magnitude.
- overflow_o  output  1  quotient magnitude saturated.
- div_by_zero_o  output  1  divisor magnitude was zero.

Behaviour:
- Reset (reset_i low, asynchronous): state IDLE. in_ready_o=1, out_valid_o=0, y_out=0, overflow_o=0, div_by_zero_o=0. All internal registers cleared. An operation in flight is discarded, with no output.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready_o=1.
  - On in_valid_i && in_ready_o: latch |a|, |b|, sign_a and sign_b. Load counter ITER = M + q_n (48 at defaults). Go to CALC.
- CALC:
  - in_ready_o=0.
  - Each cycle: shift the next dividend bit of (|a| << q_n), MSB first, into the partial remainder, then trial-subtract |b|.
  - If the remainder is >= 0, the quotient bit is 1 and the subtraction is kept; otherwise the quotient bit is 0 and the remainder is restored.
  - The counter decrements; when it reaches 0, register the result and go to DONE.
- DONE:
  - out_valid_o=1; y_out, overflow_o and div_by_zero_o are stable.
  - On out_ready_i, go to IDLE; out_valid_o drops on the next edge.
  - in_ready_o stays 0 in DONE, so there is no same-cycle accept.
- Latency: out_valid_o rises exactly ITER+1 rising edges after the accepting edge. It is fixed for all operands, including divide-by-zero.
- Arithmetic:
  - The full quotient Q is ITER bits wide. If any bit of Q above bit M-1 is set, the magnitude saturates to all-ones and overflow_o=1. Otherwise the magnitude is Q[M-1:0], truncated toward zero.
  - Sign = sign_a XOR sign_b, but it is forced to 0 whenever the result magnitude is 0 (no negative zero).
- Divide-by-zero (|b|==0, either sign bit, including 0/0):
  - Magnitude = all-ones, sign = sign_a.
  - div_by_zero_o=1, overflow_o=0.
  - The CALC phase still runs, so latency is unchanged.
- Zero dividend with non-zero divisor: y_out=0, both flags 0.
- Flags are valid only while out_valid_o=1. They are cleared on the edge that leaves DONE.
- Operand changes while not in IDLE are ignored.
- in_valid_i held high across operations: a new operation is accepted on the first IDLE cycle.

Optional Feature:
- Macro: FIXED_POINT_DIVIDER_ROUND_EN.
- Defined:
  - ITER = M + q_n + 1. One extra guard quotient bit is computed.
  - Magnitude = (Q >> 1) + Q[0], i.e. round half up on magnitude, which is symmetric about zero.
  - If rounding carries past M bits, saturate to all-ones with overflow_o=1.
  - Latency is ITER+1 = 50 at defaults.
- Undefined: truncation as described above; latency 49 at defaults.

Test Plan:
- Reset then basic divide: a=0x0_0003_0000 (3.0), b=0x0_0001_8000 (1.5) -> after 49 edges y_out=0x0_0002_0000; flags 0; in_ready_o low throughout CALC/DONE.
- Signs: a=0x1_0003_0000 (-3.0), b=0x0_0001_8000 -> 0x1_0002_0000. Repeat with a=0, b=0x1_0001_0000 -> 0x0_0000_0000 (no negative zero).
- Fraction and rounding: a=0x0_0002_0000, b=0x0_0003_0000 -> 0x0_0000_AAAA truncated; with FIXED_POINT_DIVIDER_ROUND_EN -> 0x0_0000_AAAB after 50 edges. Also 1/3 -> 0x0_0000_5555 in both builds.
- Overflow: a=0x0_8000_0000, b=0x0_0000_8000 -> y_out=0x0_FFFF_FFFF, overflow_o=1.
- Divide-by-zero: a=0x1_0005_0000, b=0x1_0000_0000 -> y_out=0x1_FFFF_FFFF, div_by_zero_o=1, overflow_o=0, latency still 49.
- Handshake and reset: hold out_ready_i=0 for 10 cycles in DONE -> y_out stable, no new accept. Then assert reset_i low mid-CALC -> outputs return to reset values immediately, and the next operation completes correctly.
